// File: rtl/binary_to_bcd_seq_if.sv
// Handshake and result bundle for binary_to_bcd_seq.
// BIN_W/DIGITS must match the parameters of the attached converter.
interface binary_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, packed BCD out.
// bcd_out/overflow update only in DONE and hold between conversions.
module binary_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  binary_to_bcd_seq_if.slave bus
);

  localparam int OUT_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [OUT_W-1:0]   scr_q, scr_d;
  logic [OUT_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               load;
  logic [OUT_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               done_q;

  // Add-3 per digit; 4-bit add, no inter-digit carry.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = scr_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        // The bit leaving the top digit is a decimal carry worth 10^DIGITS.
        scr_d = {adj[OUT_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        acc_d = acc_q | adj[OUT_W-1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      scr_q  <= scr_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      done_q <= load;
      if (load) begin
        bcd_q <= scr_q;
        ovf_q <= acc_q;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop on done.
// dut1 uses the default 3 digits; dut2 uses 2 digits to exercise overflow.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  binary_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) b1 ();
  binary_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  always @(negedge clk) begin
    if (b1.done) begin
      if (q1.size() == 0) begin
        chk("spurious_done1", {20'd0, b1.bcd_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("bcd1", {20'd0, b1.bcd_out}, {20'd0, e.bcd});
        chk("ovf1", {31'd0, b1.overflow}, {31'd0, e.ovf});
        chk("latency1", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (b2.done) begin
      if (q2.size() == 0) begin
        chk("spurious_done2", {24'd0, b2.bcd_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("bcd2", {24'd0, b2.bcd_out}, {24'd0, e.bcd[7:0]});
        chk("ovf2", {31'd0, b2.overflow}, {31'd0, e.ovf});
        chk("latency2", cyc, e.due);
      end
    end
  end

  task automatic accept(input int sel, input logic [7:0] v);
    @(negedge clk);
    if (sel == 1) begin b1.start = 1'b1; b1.bin_in = v; end
    else          begin b2.start = 1'b1; b2.bin_in = v; end
    @(posedge clk);
    #1;
  endtask

  // Issue one conversion and return just after its done edge.
  task automatic conv(input int sel, input logic [7:0] v, input logic [11:0] e_bcd,
                      input logic e_ovf, input bit hold);
    exp_t e;
    accept(sel, v);
    e.bcd = e_bcd;
    e.ovf = e_ovf;
    e.due = cyc + 9;
    if (sel == 1) begin
      q1.push_back(e);
      chk("busy_after_accept1", {31'd0, b1.busy}, 32'd1);
      if (!hold) b1.start = 1'b0;
    end else begin
      q2.push_back(e);
      chk("busy_after_accept2", {31'd0, b2.busy}, 32'd1);
      if (!hold) b2.start = 1'b0;
    end
    repeat (9) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    b1.start = 1'b0; b1.bin_in = '0;
    b2.start = 1'b0; b2.bin_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, b1.busy}, 32'd0);
      chk("idle_done", {31'd0, b1.done}, 32'd0);
      chk("idle_bcd", {20'd0, b1.bcd_out}, 32'd0);
      chk("idle_ovf", {31'd0, b1.overflow}, 32'd0);
    end
    chk("idle_bcd2", {24'd0, b2.bcd_out}, 32'd0);

    conv(1, 8'd255, 12'h255, 1'b0, 1'b0);
    chk("busy_after_done", {31'd0, b1.busy}, 32'd0);
    conv(1, 8'd0,   12'h000, 1'b0, 1'b0);
    conv(1, 8'd99,  12'h099, 1'b0, 1'b0);
    conv(1, 8'd200, 12'h200, 1'b0, 1'b0);
    conv(1, 8'd9,   12'h009, 1'b0, 1'b0);
    chk("hold_bcd", {20'd0, b1.bcd_out}, 32'h009);

    // start pulsed during CONV must be ignored
    accept(1, 8'd128);
    e.bcd = 12'h128; e.ovf = 1'b0; e.due = cyc + 9;
    q1.push_back(e);
    b1.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    b1.start = 1'b1; b1.bin_in = 8'd7;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    conv(1, 8'd7, 12'h007, 1'b0, 1'b0);

    // bin_in changed right after acceptance
    accept(1, 8'd63);
    e.bcd = 12'h063; e.ovf = 1'b0; e.due = cyc + 9;
    q1.push_back(e);
    b1.start = 1'b0; b1.bin_in = 8'd0;
    repeat (9) @(posedge clk);
    #1;

    // asynchronous reset mid-conversion: no done, outputs cleared at once
    accept(1, 8'd255);
    b1.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, b1.busy}, 32'd0);
    chk("rst_done", {31'd0, b1.done}, 32'd0);
    chk("rst_bcd", {20'd0, b1.bcd_out}, 32'd0);
    chk("rst_ovf", {31'd0, b1.overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    conv(1, 8'd42, 12'h042, 1'b0, 1'b0);

    // overflow on the two-digit instance
    conv(2, 8'd255, 12'h055, 1'b1, 1'b0);
    conv(2, 8'd99,  12'h099, 1'b0, 1'b0);
    conv(2, 8'd100, 12'h000, 1'b1, 1'b0);

    // full sweep with start held high (back-to-back)
    for (int v = 0; v < 256; v++)
      conv(1, 8'(v), ref_bcd(v), 1'b0, 1'b1);
    b1.start = 1'b0;

    for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++)
      @(negedge clk);
    if (q1.size() != 0) chk("missing_done1", q1.size(), 0);
    if (q2.size() != 0) chk("missing_done2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
